// File: rtl/myproject_udiv_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   state_t              : divider FSM states (IDLE, CALC, DONE)
//   DIVIDEND_WIDTH_DEF   : default dividend/quotient width
//   DIVISOR_WIDTH_DEF    : default divisor/remainder width
//   CNT_W_DEF            : step counter width for the default dividend width
package myproject_udiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIVIDEND_WIDTH_DEF = 28;
   localparam int DIVISOR_WIDTH_DEF  = 14;
   localparam int CNT_W_DEF          = $clog2(DIVIDEND_WIDTH_DEF);

endpackage

// File: rtl/myproject_udiv_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   p_in    in  DIVISOR_WIDTH  partial remainder before the step (always < divisor)
//   bit_in  in  1              next dividend bit, MSB first
//   divisor in  DIVISOR_WIDTH  denominator
//   p_out   out DIVISOR_WIDTH  partial remainder after the step
//   qbit    out 1              quotient bit produced by this step
module myproject_udiv_step #(
   parameter int DIVISOR_WIDTH = 14
) (
   input  logic [DIVISOR_WIDTH-1:0] p_in,
   input  logic                     bit_in,
   input  logic [DIVISOR_WIDTH-1:0] divisor,
   output logic [DIVISOR_WIDTH-1:0] p_out,
   output logic                     qbit
);

   // The shifted remainder needs one guard bit so the compare sees values up
   // to 2*divisor-1; after a conditional subtract it fits back in the width.
   logic [DIVISOR_WIDTH:0]   p_sh;
   logic [DIVISOR_WIDTH-1:0] diff;

   assign p_sh  = {p_in, bit_in};
   // Only the low bits of the difference matter: when it is taken, the true
   // result is below the divisor, so modular subtraction is exact.
   assign diff  = p_sh[DIVISOR_WIDTH-1:0] - divisor;
   assign qbit  = (p_sh >= {1'b0, divisor});
   assign p_out = qbit ? diff : p_sh[DIVISOR_WIDTH-1:0];

endmodule

// File: rtl/myproject_udiv_28ns_14ns_seq.sv
// Sequential unsigned divider, restoring radix-2, one quotient bit per clock.
// Single operation in flight; valid/ready handshakes on input and output.
// Optional macro MYPROJECT_UDIV_FASTPATH_EN: divisor==0 or dividend<divisor
// skips the CALC phase and reaches DONE on the accept edge.
// Ports:
//   ap_clk, ap_rst         clock (rising), async active-high reset
//   in_vld/in_rdy          operand handshake; dividend/divisor sampled on accept
//   out_vld/out_rdy        result handshake; outputs held while out_vld
//   quotient, remainder    floor(dividend/divisor), dividend mod divisor
//   div_by_zero            result came from divisor==0 (quotient all ones,
//                          remainder = low bits of dividend)
module myproject_udiv_28ns_14ns_seq
   import myproject_udiv_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
   parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic                      in_vld,
   output logic                      in_rdy,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero
);

   localparam int CNT_W = $clog2(DIVIDEND_WIDTH);

   state_t                    state, state_nxt;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB,
   // so one register serves both during CALC.
   logic [DIVIDEND_WIDTH-1:0] dvd_sr;
   logic [DIVISOR_WIDTH-1:0]  dvs;
   logic [DIVISOR_WIDTH-1:0]  dvd_lo;
   logic [DIVISOR_WIDTH-1:0]  p;
   logic [CNT_W-1:0]          cnt;

   logic [DIVISOR_WIDTH-1:0]  p_nxt;
   logic                      qbit;
   logic                      last;
   logic                      fast;
   logic                      dvs_zero;

   myproject_udiv_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
      .p_in    (p),
      .bit_in  (dvd_sr[DIVIDEND_WIDTH-1]),
      .divisor (dvs),
      .p_out   (p_nxt),
      .qbit    (qbit)
   );

   assign last     = (cnt == CNT_W'(DIVIDEND_WIDTH - 1));
   assign dvs_zero = (dvs == '0);

`ifdef MYPROJECT_UDIV_FASTPATH_EN
   // Trivial cases whose result is known at accept time.
   assign fast = (divisor == '0) ||
                 (dividend < {{(DIVIDEND_WIDTH-DIVISOR_WIDTH){1'b0}}, divisor});
`else
   assign fast = 1'b0;
`endif

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      out_vld   = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_vld) state_nxt = fast ? DONE : CALC;
         end
         CALC: if (last) state_nxt = DONE;
         DONE: begin
            out_vld = 1'b1;
            if (out_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         dvd_sr      <= '0;
         dvs         <= '0;
         dvd_lo      <= '0;
         p           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_vld) begin
               dvd_sr <= dividend;
               dvs    <= divisor;
               dvd_lo <= dividend[DIVISOR_WIDTH-1:0];
               p      <= '0;
               cnt    <= '0;
               if (fast) begin
                  // dividend<divisor: q=0, r=dividend (fits the remainder width)
                  quotient    <= (divisor == '0) ? '1 : '0;
                  remainder   <= dividend[DIVISOR_WIDTH-1:0];
                  div_by_zero <= (divisor == '0);
               end
            end
            CALC: begin
               dvd_sr <= {dvd_sr[DIVIDEND_WIDTH-2:0], qbit};
               p      <= p_nxt;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  quotient    <= dvs_zero ? '1 : {dvd_sr[DIVIDEND_WIDTH-2:0], qbit};
                  remainder   <= dvs_zero ? dvd_lo : p_nxt;
                  div_by_zero <= dvs_zero;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_myproject_udiv_28ns_14ns_seq.sv
// Directed bench for the sequential divider: reset state, several divisions,
// divide-by-zero, output back-pressure, and reset in the middle of CALC.
module tb_myproject_udiv_28ns_14ns_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [27:0] dividend = '0;
   logic [13:0] divisor  = '0;
   logic        out_vld;
   logic        out_rdy = 1'b1;
   logic [27:0] quotient;
   logic [13:0] remainder;
   logic        div_by_zero;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef MYPROJECT_UDIV_FASTPATH_EN
   localparam int FAST_LAT = 0;  // out_vld in the cycle right after the accept edge
`else
   localparam int FAST_LAT = 28;
`endif

   myproject_udiv_28ns_14ns_seq dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_vld      (in_vld),
      .in_rdy      (in_rdy),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Issue one operation and wait for out_vld; entered #1 after an edge in IDLE.
   // lat counts edges after the accept edge until out_vld is seen.
   task automatic do_op(input string tag, input logic [27:0] a, input logic [13:0] b,
                        input logic [27:0] eq, input logic [13:0] er,
                        input logic ez, input int elat);
      int lat = 0;
      chk({tag, ".in_rdy_idle"}, 32'(in_rdy), 32'd1);
      in_vld   = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      in_vld   = 1'b0;
      dividend = 28'h5A5A5A5;  // changes after accept must not matter
      divisor  = 14'h0003;
      chk({tag, ".in_rdy_busy"}, 32'(in_rdy), 32'd0);
      while (!out_vld && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(elat));
      chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
      chk({tag, ".remainder"}, 32'(remainder), 32'(er));
      chk({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
      if (out_rdy) begin
         tick();
         chk({tag, ".out_vld_after"}, 32'(out_vld), 32'd0);
      end
   endtask

   initial begin
      #12;
      chk("rst.in_rdy", 32'(in_rdy), 32'd1);
      chk("rst.out_vld", 32'(out_vld), 32'd0);
      chk("rst.quotient", 32'(quotient), 32'd0);
      chk("rst.remainder", 32'(remainder), 32'd0);
      chk("rst.dbz", 32'(div_by_zero), 32'd0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      tick();

      do_op("d1000_7", 28'd1000, 14'd7, 28'd142, 14'd6, 1'b0, 28);
      do_op("dmax_3fff", 28'hFFFFFFF, 14'h3FFF, 28'h0004001, 14'd0, 1'b0, 28);
      do_op("dmax_1", 28'hFFFFFFF, 14'd1, 28'hFFFFFFF, 14'd0, 1'b0, 28);
      do_op("dzero", 28'h0001234, 14'd0, 28'hFFFFFFF, 14'h1234, 1'b1, FAST_LAT);
      do_op("d5_9", 28'd5, 14'd9, 28'd0, 14'd5, 1'b0, FAST_LAT);

      // Back-pressure: result must sit still and new requests be ignored.
      out_rdy = 1'b0;
      do_op("stall", 28'd1000, 14'd7, 28'd142, 14'd6, 1'b0, 28);
      in_vld   = 1'b1;
      dividend = 28'd77;
      divisor  = 14'd2;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall.out_vld", 32'(out_vld), 32'd1);
         chk("stall.in_rdy", 32'(in_rdy), 32'd0);
         chk("stall.quotient", 32'(quotient), 32'd142);
         chk("stall.remainder", 32'(remainder), 32'd6);
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      tick();
      chk("stall.out_vld_after", 32'(out_vld), 32'd0);
      chk("stall.in_rdy_after", 32'(in_rdy), 32'd1);

      // Reset at CALC step 12 discards the operation.
      in_vld   = 1'b1;
      dividend = 28'd1000;
      divisor  = 14'd7;
      tick();
      in_vld = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      ap_rst = 1'b1;
      #1;
      chk("mrst.in_rdy", 32'(in_rdy), 32'd1);
      chk("mrst.out_vld", 32'(out_vld), 32'd0);
      chk("mrst.quotient", 32'(quotient), 32'd0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("mrst.no_out_vld", 32'(out_vld), 32'd0);
      end
      do_op("d100_10", 28'd100, 14'd10, 28'd10, 14'd0, 1'b0, 28);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
